// File: rtl/reset_teardown_sequencer_pkg.sv
// Shared definitions for the staged reset sequencer: state encoding and
// default timing values also used by the power-up delay logic.
package reset_teardown_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RELEASE    = 3'd0,
        ST_RUN        = 3'd1,
        ST_TEAR_WAIT  = 3'd2,
        ST_TEAR_DELAY = 3'd3,
        ST_HOLD       = 3'd4
    } state_e;

    localparam int unsigned DEF_NUM_STAGES  = 3;
    localparam int unsigned DEF_CNT_W       = 22;
    localparam int unsigned DEF_STAGE_DELAY = 32'h000F_FFFF;
    localparam int unsigned DEF_ACK_TIMEOUT = 32'h003F_FFFF;
    localparam int unsigned DEF_HOLD_CYCLES = 32'h000F_FFFF;

    // True when value v is representable in an unsigned counter of w bits.
    function automatic bit fits_in(input longint unsigned v, input int unsigned w);
        return v < (64'd1 << w);
    endfunction

endpackage

// File: rtl/reset_teardown_sequencer_sync_2ff.sv
// Two-flop synchronizer, per-bit, with asynchronous active-low clear.
module sync_2ff
    import reset_teardown_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [WIDTH-1:0] iD,
    output logic [WIDTH-1:0] oQ
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= iD;
            sync_q <= meta_q;
        end
    end

    assign oQ = sync_q;

endmodule

// File: rtl/reset_teardown_sequencer.sv
// Staged reset controller: ascending release at power-up, reverse-order
// teardown (ack or timeout gated) on soft-reset request, then re-release.
module reset_teardown_sequencer
    import reset_teardown_sequencer_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned STAGE_DELAY = DEF_STAGE_DELAY,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iREQ,
    input  logic [NUM_STAGES-1:0] iACK,
    output logic [NUM_STAGES-1:0] oRST,
    output logic                  oBUSY,
    output logic                  oDONE,
    output logic                  oTIMEOUT,
    output logic [2:0]            oSTATE
);

    localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_STAGES - 1);

    if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_num_stages
        $error("NUM_STAGES must be in 1..8");
    end
    if (STAGE_DELAY < 2 || !fits_in(STAGE_DELAY, CNT_W)) begin : g_bad_stage_delay
        $error("STAGE_DELAY must be >=2 and fit in CNT_W bits");
    end
    if (ACK_TIMEOUT < 2 || !fits_in(ACK_TIMEOUT, CNT_W)) begin : g_bad_ack_timeout
        $error("ACK_TIMEOUT must be >=2 and fit in CNT_W bits");
    end
    if (HOLD_CYCLES < 1 || !fits_in(HOLD_CYCLES, CNT_W)) begin : g_bad_hold_cycles
        $error("HOLD_CYCLES must be >=1 and fit in CNT_W bits");
    end

    logic [NUM_STAGES-1:0] ack_s;

    sync_2ff #(.WIDTH(NUM_STAGES)) u_ack_sync (
        .iCLK (iCLK),
        .iRST (iRST),
        .iD   (iACK),
        .oQ   (ack_s)
    );

    state_e                state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic                  pending_q, pending_d;
    logic                  soft_q,    soft_d;
    logic [NUM_STAGES-1:0] rst_q,     rst_d;
    logic                  done_q,    done_d;
    logic                  timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        soft_d    = soft_q;
        rst_d     = rst_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;

        case (state_q)
            ST_RELEASE: begin
                // Requests seen during release collapse into one pending teardown.
                if (iREQ) pending_d = 1'b1;
                if (cnt_q == DELAY_LAST) begin
                    rst_d[idx_q] = 1'b1;
                    cnt_d        = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        if (soft_q) begin
                            done_d = 1'b1;
                            soft_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (iREQ || pending_q) begin
                    state_d   = ST_TEAR_WAIT;
                    idx_d     = IDX_LAST;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                    soft_d    = 1'b1;
                    timeout_d = 1'b0;
                end
            end

            ST_TEAR_WAIT: begin
                // Acknowledge takes priority over a coincident timeout.
                if (ack_s[idx_q] || cnt_q == TIMEOUT_LAST) begin
                    rst_d[idx_q] = 1'b0;
                    cnt_d        = '0;
                    state_d      = ST_TEAR_DELAY;
                    if (!ack_s[idx_q]) timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_TEAR_DELAY: begin
                if (cnt_q == DELAY_LAST) begin
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        state_d = ST_HOLD;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = ST_TEAR_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                rst_d = '0;
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_RELEASE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q   <= ST_RELEASE;
            cnt_q     <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            soft_q    <= 1'b0;
            rst_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            soft_q    <= soft_d;
            rst_q     <= rst_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign oRST     = rst_q;
    assign oDONE    = done_q;
    assign oTIMEOUT = timeout_q;
    assign oBUSY    = (state_q != ST_RUN);
    assign oSTATE   = state_q;

endmodule
